// File: rtl/rob_tid_issuer_if.sv
// rob_tid_issuer_if
//   Bundles the AR request channel, the tagged request channel towards tag
//   compare and the ROB retire/lookup port of the tID issuer.
//   slave  : the issuer side (rob_tid_issuer)
//   master : the environment side (AXI master + tag compare + ROB)
//   Signal names keep the issuer's view: *_i are driven into the issuer,
//   *_o are driven by it.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

interface rob_tid_issuer_if #(
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int TID_WIDTH  = `TID_WIDTH
) ();
  logic                  arvalid_i;
  logic                  arready_o;
  logic [ID_WIDTH-1:0]   arid_i;
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [TID_WIDTH-1:0]  req_tid_o;
  logic [ADDR_WIDTH-1:0] req_addr_o;
  logic                  retire_i;
  logic [TID_WIDTH-1:0]  retire_tid_i;
  logic [ID_WIDTH-1:0]   retire_id_o;
  logic [TID_WIDTH:0]    outstanding_o;
  logic                  err_o;

  modport slave (
    input  arvalid_i, arid_i, araddr_i, req_ready_i, retire_i, retire_tid_i,
    output arready_o, req_valid_o, req_tid_o, req_addr_o, retire_id_o,
           outstanding_o, err_o
  );

  modport master (
    output arvalid_i, arid_i, araddr_i, req_ready_i, retire_i, retire_tid_i,
    input  arready_o, req_valid_o, req_tid_o, req_addr_o, retire_id_o,
           outstanding_o, err_o
  );
endinterface

// File: rtl/rob_tid_issuer.sv
// rob_tid_issuer
//   Stamps each accepted AXI read-address request with a sequential tID
//   (first tID after reset is 1, wraps modulo 2**TID_WIDTH), forwards
//   {tID, address} to tag compare through a one-entry output slot, records the
//   AXI ID per tID for the ROB and limits outstanding requests so that tIDs
//   never alias.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : rob_tid_issuer_if.slave
//           AR in (arvalid_i/arready_o/arid_i/araddr_i),
//           tagged request out (req_valid_o/req_ready_i/req_tid_o/req_addr_o),
//           retire in + ID lookup (retire_i/retire_tid_i/retire_id_o),
//           status (outstanding_o, sticky err_o)

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif

module rob_tid_issuer #(
  parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH        = `AXI_ID_WIDTH,
  parameter int TID_WIDTH       = `TID_WIDTH,
  parameter int MAX_OUTSTANDING = 2**TID_WIDTH - 1
) (
  input logic              clk,
  input logic              rst_n,
  rob_tid_issuer_if.slave  bus
);

  localparam int DEPTH = 2**TID_WIDTH;
  localparam logic [TID_WIDTH:0]   MAX_OUT_C = (TID_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [TID_WIDTH-1:0] TID_ONE_C = TID_WIDTH'(1'b1);
  localparam logic [TID_WIDTH:0]   CNT_ONE_C = (TID_WIDTH+1)'(1'b1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_VAL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [TID_WIDTH-1:0]  next_tid_q, next_tid_d;
  logic [TID_WIDTH-1:0]  oldest_tid_q, oldest_tid_d;
  logic [TID_WIDTH:0]    outstanding_q, outstanding_d;
  logic                  req_valid_q, req_valid_d;
  logic [TID_WIDTH-1:0]  req_tid_q, req_tid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DEPTH-1:0]      live_q, live_d;
  logic                  err_q, err_d;
  logic [ID_WIDTH-1:0]   id_table_q [DEPTH];

  logic arready_s;
  logic accept_s;
  logic retire_ok_s;

  // The slot can take a new request when empty or draining this cycle; credit
  // uses the registered count, so a retire frees credit one cycle later.
  assign arready_s   = ((state_q == S_IDLE) | bus.req_ready_i) & (outstanding_q < MAX_OUT_C);
  assign accept_s    = bus.arvalid_i & arready_s;
  // Only in-order retirement of a live entry is legal; a live oldest entry
  // also implies a non-zero count, so underflow is covered here.
  assign retire_ok_s = bus.retire_i & (bus.retire_tid_i == oldest_tid_q) & live_q[bus.retire_tid_i];

  // Next-state computation for the slot FSM, counters, live bits and error flag.
  always_comb begin
    state_d       = state_q;
    next_tid_d    = next_tid_q;
    oldest_tid_d  = oldest_tid_q;
    outstanding_d = outstanding_q;
    req_tid_d     = req_tid_q;
    req_addr_d    = req_addr_q;
    live_d        = live_q;
    err_d         = err_q;

    // Retire is applied before the accept so that a same-cycle set of a
    // different entry is never masked.
    if (retire_ok_s) begin
      live_d[bus.retire_tid_i] = 1'b0;
      oldest_tid_d             = oldest_tid_q + TID_ONE_C;
    end else if (bus.retire_i) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (accept_s) begin
      live_d[next_tid_q] = 1'b1;
      next_tid_d         = next_tid_q + TID_ONE_C;
    end else begin
      next_tid_d = next_tid_q;
    end

    case ({accept_s, retire_ok_s})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE_C;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE_C;
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d    = S_VAL;
          req_tid_d  = next_tid_q;
          req_addr_d = bus.araddr_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_VAL: begin
        // An accept here implies req_ready_i, so the slot reloads in place.
        if (accept_s) begin
          state_d    = S_VAL;
          req_tid_d  = next_tid_q;
          req_addr_d = bus.araddr_i;
        end else if (bus.req_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_VAL;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_valid_d = (state_d == S_VAL);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      next_tid_q    <= TID_ONE_C;
      oldest_tid_q  <= TID_ONE_C;
      outstanding_q <= '0;
      req_valid_q   <= 1'b0;
      req_tid_q     <= '0;
      req_addr_q    <= '0;
      live_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      next_tid_q    <= next_tid_d;
      oldest_tid_q  <= oldest_tid_d;
      outstanding_q <= outstanding_d;
      req_valid_q   <= req_valid_d;
      req_tid_q     <= req_tid_d;
      req_addr_q    <= req_addr_d;
      live_q        <= live_d;
      err_q         <= err_d;
    end
  end

  // AXI ID storage; contents are meaningful only while the live bit is set,
  // so the array carries no reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      id_table_q[next_tid_q] <= bus.arid_i;
    end
  end

  assign bus.arready_o     = arready_s;
  assign bus.req_valid_o   = req_valid_q;
  assign bus.req_tid_o     = req_tid_q;
  assign bus.req_addr_o    = req_addr_q;
  assign bus.retire_id_o   = id_table_q[bus.retire_tid_i];
  assign bus.outstanding_o = outstanding_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_rob_tid_issuer.sv
// Testbench for rob_tid_issuer (TID_WIDTH=4, MAX_OUTSTANDING=15).
// Reference model: in-flight tIDs kept as an ordered queue, tID counter as
// plain modulo arithmetic, one-entry output slot as a valid/tid/addr triple.
module tb_rob_tid_issuer;
  localparam int AW   = 32;
  localparam int IW   = 4;
  localparam int TW   = 4;
  localparam int MAXO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_tid_issuer_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW)) bus ();

  rob_tid_issuer #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int            m_next_tid;
  int            m_inflight[$];
  logic [IW-1:0] m_id [16];
  bit            m_err;
  bit            m_slot_v;
  int            m_slot_tid;
  logic [AW-1:0] m_slot_addr;

  // per-cycle observations and model predictions
  bit            exp_arready;
  logic          obs_arready;
  logic [IW-1:0] obs_retire_id;
  logic [IW-1:0] exp_retire_id;
  bit            last_acc;
  bit            last_ret_ok;

  task automatic model_reset();
    m_next_tid  = 1;
    m_inflight.delete();
    m_err       = 1'b0;
    m_slot_v    = 1'b0;
    m_slot_tid  = 0;
    m_slot_addr = '0;
  endtask

  // Drive one cycle, sample combinational outputs before the edge, advance
  // the model, then land 1 time unit after the rising edge.
  task automatic tick(input bit arv, input logic [IW-1:0] arid, input logic [AW-1:0] addr,
                      input bit rdy, input bit ret, input logic [TW-1:0] rtid);
    bus.arvalid_i    = arv;
    bus.arid_i       = arid;
    bus.araddr_i     = addr;
    bus.req_ready_i  = rdy;
    bus.retire_i     = ret;
    bus.retire_tid_i = rtid;
    #1;
    obs_arready   = bus.arready_o;
    obs_retire_id = bus.retire_id_o;
    exp_retire_id = m_id[int'(rtid)];
    exp_arready   = (!m_slot_v || rdy) && (m_inflight.size() < MAXO);
    last_acc      = arv && exp_arready;
    last_ret_ok   = 1'b0;
    if (ret) begin
      if (m_inflight.size() > 0 && m_inflight[0] == int'(rtid)) begin
        last_ret_ok = 1'b1;
        void'(m_inflight.pop_front());
      end else begin
        m_err = 1'b1;
      end
    end
    if (last_acc) begin
      m_inflight.push_back(m_next_tid);
      m_id[m_next_tid] = arid;
      m_slot_v    = 1'b1;
      m_slot_tid  = m_next_tid;
      m_slot_addr = addr;
      m_next_tid  = (m_next_tid + 1) % 16;
    end else if (rdy) begin
      m_slot_v = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.arvalid_i = 1'b0;
    bus.retire_i  = 1'b0;
  endtask

  task automatic do_reset(input bit arv);
    rst_n            = 1'b0;
    bus.arvalid_i    = arv;
    bus.arid_i       = IW'($urandom);
    bus.araddr_i     = AW'($urandom);
    bus.req_ready_i  = 1'b0;
    bus.retire_i     = 1'b0;
    bus.retire_tid_i = '0;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.arvalid_i = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (bus.arready_o !== 1'b1) begin errors++; $display("FAIL reset_arready: got %0b exp 1", bus.arready_o); end
    checks++; if (bus.req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b exp 0", bus.req_valid_o); end
    checks++; if (bus.req_tid_o !== 4'h0) begin errors++; $display("FAIL reset_req_tid: got %0h exp 0", bus.req_tid_o); end
    checks++; if (bus.req_addr_o !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %0h exp 0", bus.req_addr_o); end
    checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", bus.outstanding_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", bus.err_o); end
  endtask

  task automatic test_single();
    do_reset(1'b0);
    tick(1'b1, 4'h3, 32'h0000_1000, 1'b1, 1'b0, 4'h0);
    checks++; if (obs_arready !== 1'b1) begin errors++; $display("FAIL single_arready: got %0b exp 1", obs_arready); end
    checks++; if (bus.req_valid_o !== 1'b1) begin errors++; $display("FAIL single_req_valid: got %0b exp 1", bus.req_valid_o); end
    checks++; if (bus.req_tid_o !== 4'h1) begin errors++; $display("FAIL single_req_tid: got %0h exp 1", bus.req_tid_o); end
    checks++; if (bus.req_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL single_req_addr: got %0h exp 1000", bus.req_addr_o); end
    checks++; if (bus.outstanding_o !== 5'd1) begin errors++; $display("FAIL single_outstanding: got %0d exp 1", bus.outstanding_o); end
    tick(1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h1);
    checks++; if (obs_retire_id !== 4'h3) begin errors++; $display("FAIL single_retire_id: got %0h exp 3", obs_retire_id); end
    checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL single_outstanding_after: got %0d exp 0", bus.outstanding_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %0b exp 0", bus.err_o); end
    checks++; if (bus.req_valid_o !== 1'b0) begin errors++; $display("FAIL single_req_drained: got %0b exp 0", bus.req_valid_o); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a [3];
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) a[i] = AW'($urandom);
    // The master holds the second request valid while it is refused.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'h1, (i == 0) ? a[0] : a[1], 1'b0, 1'b0, 4'h0);
      checks++; if (obs_arready !== (i == 0)) begin errors++; $display("FAIL bp_arready[%0d]: got %0b exp %0b", i, obs_arready, (i == 0)); end
      checks++; if (bus.req_valid_o !== 1'b1 || bus.req_tid_o !== 4'h1 || bus.req_addr_o !== a[0]) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%0b tid=%0h addr=%0h exp v=1 tid=1 addr=%0h", i, bus.req_valid_o, bus.req_tid_o, bus.req_addr_o, a[0]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      tick(1'b1, IW'(i), a[i], 1'b1, 1'b0, 4'h0);
      checks++; if (bus.req_valid_o !== 1'b1 || bus.req_tid_o !== TW'(i + 1) || bus.req_addr_o !== a[i]) begin
        errors++; $display("FAIL bp_drain[%0d]: got v=%0b tid=%0h addr=%0h exp v=1 tid=%0h addr=%0h", i, bus.req_valid_o, bus.req_tid_o, bus.req_addr_o, i + 1, a[i]);
      end
    end
    tick(1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0);
    checks++; if (bus.req_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %0b exp 0", bus.req_valid_o); end
    checks++; if (bus.outstanding_o !== 5'd3) begin errors++; $display("FAIL bp_outstanding: got %0d exp 3", bus.outstanding_o); end
  endtask

  task automatic test_credit();
    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1'b1, IW'($urandom), AW'($urandom), 1'b1, 1'b0, 4'h0);
      checks++; if (obs_arready !== 1'b1 || bus.req_tid_o !== TW'(i + 1)) begin
        errors++; $display("FAIL credit_fill[%0d]: got rdy=%0b tid=%0h exp rdy=1 tid=%0h", i, obs_arready, bus.req_tid_o, i + 1);
      end
    end
    tick(1'b1, 4'h5, 32'h0000_2000, 1'b1, 1'b0, 4'h0);
    checks++; if (obs_arready !== 1'b0) begin errors++; $display("FAIL credit_full_arready: got %0b exp 0", obs_arready); end
    checks++; if (bus.outstanding_o !== 5'd15) begin errors++; $display("FAIL credit_full_count: got %0d exp 15", bus.outstanding_o); end
    // Retire and request together at the limit: request still blocked.
    tick(1'b1, 4'h5, 32'h0000_2000, 1'b1, 1'b1, 4'h1);
    checks++; if (obs_arready !== 1'b0) begin errors++; $display("FAIL credit_same_cycle: got %0b exp 0", obs_arready); end
    checks++; if (bus.outstanding_o !== 5'd14) begin errors++; $display("FAIL credit_after_retire: got %0d exp 14", bus.outstanding_o); end
    tick(1'b1, 4'h5, 32'h0000_2000, 1'b1, 1'b0, 4'h0);
    checks++; if (obs_arready !== 1'b1) begin errors++; $display("FAIL credit_reopen: got %0b exp 1", obs_arready); end
    checks++; if (bus.req_tid_o !== 4'h0 || bus.req_valid_o !== 1'b1) begin errors++; $display("FAIL credit_tid0: got v=%0b tid=%0h exp v=1 tid=0", bus.req_valid_o, bus.req_tid_o); end
  endtask

  task automatic test_wrap_random();
    int acc_n = 0;
    int ret_n = 0;
    bit arv, rdy, ret;
    logic [TW-1:0] rtid;
    logic [AW-1:0] addr;
    do_reset(1'b0);
    for (int cyc = 0; cyc < 600 && ret_n < 40; cyc++) begin
      arv  = (acc_n < 40) && ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      ret  = (m_inflight.size() > 0) && ($urandom_range(0, 1) == 1);
      rtid = ret ? TW'(m_inflight[0]) : TW'($urandom);
      addr = AW'($urandom);
      tick(arv, IW'($urandom), addr, rdy, ret, rtid);
      checks++; if (obs_arready !== exp_arready) begin errors++; $display("FAIL wrap_arready c%0d: got %0b exp %0b", cyc, obs_arready, exp_arready); end
      if (last_ret_ok) begin
        ret_n++;
        checks++; if (obs_retire_id !== exp_retire_id) begin errors++; $display("FAIL wrap_retire_id tid%0h: got %0h exp %0h", rtid, obs_retire_id, exp_retire_id); end
      end
      if (last_acc) begin
        acc_n++;
        checks++; if (bus.req_tid_o !== TW'(acc_n % 16) || bus.req_addr_o !== addr) begin
          errors++; $display("FAIL wrap_issue #%0d: got tid=%0h addr=%0h exp tid=%0h addr=%0h", acc_n, bus.req_tid_o, bus.req_addr_o, acc_n % 16, addr);
        end
      end
      checks++; if (bus.req_valid_o !== m_slot_v) begin errors++; $display("FAIL wrap_req_valid c%0d: got %0b exp %0b", cyc, bus.req_valid_o, m_slot_v); end
      if (m_slot_v) begin
        checks++; if (bus.req_tid_o !== TW'(m_slot_tid) || bus.req_addr_o !== m_slot_addr) begin
          errors++; $display("FAIL wrap_slot c%0d: got tid=%0h addr=%0h exp tid=%0h addr=%0h", cyc, bus.req_tid_o, bus.req_addr_o, m_slot_tid, m_slot_addr);
        end
      end
      checks++; if (bus.outstanding_o !== (TW+1)'(m_inflight.size())) begin errors++; $display("FAIL wrap_outstanding c%0d: got %0d exp %0d", cyc, bus.outstanding_o, m_inflight.size()); end
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL wrap_err c%0d: got %0b exp 0", cyc, bus.err_o); end
    end
    checks++; if (ret_n < 40) begin errors++; $display("FAIL wrap_budget: retired %0d exp 40", ret_n); end
  endtask

  task automatic test_protocol_error();
    do_reset(1'b0);
    tick(1'b1, 4'h7, 32'h10, 1'b1, 1'b0, 4'h0);
    tick(1'b1, 4'h8, 32'h20, 1'b1, 1'b0, 4'h0);
    tick(1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h2);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL perr_order_err: got %0b exp 1", bus.err_o); end
    checks++; if (bus.outstanding_o !== 5'd2) begin errors++; $display("FAIL perr_order_count: got %0d exp 2", bus.outstanding_o); end
    tick(1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h1);
    checks++; if (bus.err_o !== 1'b1 || bus.outstanding_o !== 5'd1) begin errors++; $display("FAIL perr_sticky: got err=%0b cnt=%0d exp err=1 cnt=1", bus.err_o, bus.outstanding_o); end
    do_reset(1'b0);
    tick(1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 4'h1);
    checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL perr_empty_err: got %0b exp 1", bus.err_o); end
    checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL perr_empty_count: got %0d exp 0", bus.outstanding_o); end
  endtask

  task automatic test_simultaneous();
    logic [IW-1:0] ids [7];
    do_reset(1'b0);
    for (int i = 1; i <= 6; i++) ids[i] = IW'($urandom);
    for (int i = 1; i <= 5; i++) tick(1'b1, ids[i], AW'(i), 1'b1, 1'b0, 4'h0);
    tick(1'b1, ids[6], 32'h60, 1'b1, 1'b1, 4'h1);
    checks++; if (obs_arready !== 1'b1) begin errors++; $display("FAIL simul_arready: got %0b exp 1", obs_arready); end
    checks++; if (obs_retire_id !== ids[1]) begin errors++; $display("FAIL simul_retire_id: got %0h exp %0h", obs_retire_id, ids[1]); end
    checks++; if (bus.outstanding_o !== 5'd5) begin errors++; $display("FAIL simul_count: got %0d exp 5", bus.outstanding_o); end
    checks++; if (bus.req_tid_o !== 4'h6) begin errors++; $display("FAIL simul_tid: got %0h exp 6", bus.req_tid_o); end
    for (int t = 2; t <= 6; t++) begin
      tick(1'b0, 4'h0, 32'h0, 1'b1, 1'b1, TW'(t));
      checks++; if (obs_retire_id !== ids[t] || bus.err_o !== 1'b0) begin
        errors++; $display("FAIL simul_drain tid%0d: got id=%0h err=%0b exp id=%0h err=0", t, obs_retire_id, bus.err_o, ids[t]);
      end
    end
    checks++; if (bus.outstanding_o !== 5'd0) begin errors++; $display("FAIL simul_final_count: got %0d exp 0", bus.outstanding_o); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick(1'b1, 4'h2, 32'hABCD, 1'b0, 1'b0, 4'h0);
    tick(1'b1, 4'h2, 32'hBEEF, 1'b0, 1'b0, 4'h0);
    do_reset(1'b1);
    checks++; if (bus.req_valid_o !== 1'b0 || bus.req_tid_o !== 4'h0 || bus.req_addr_o !== 32'h0) begin
      errors++; $display("FAIL rmid_slot: got v=%0b tid=%0h addr=%0h exp 0/0/0", bus.req_valid_o, bus.req_tid_o, bus.req_addr_o);
    end
    checks++; if (bus.outstanding_o !== 5'd0 || bus.err_o !== 1'b0 || bus.arready_o !== 1'b1) begin
      errors++; $display("FAIL rmid_status: got cnt=%0d err=%0b rdy=%0b exp 0/0/1", bus.outstanding_o, bus.err_o, bus.arready_o);
    end
    tick(1'b1, 4'h9, 32'h3000, 1'b1, 1'b0, 4'h0);
    checks++; if (bus.req_tid_o !== 4'h1 || bus.req_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_first_tid: got v=%0b tid=%0h exp v=1 tid=1", bus.req_valid_o, bus.req_tid_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arvalid_i    = 1'b0;
    bus.arid_i       = '0;
    bus.araddr_i     = '0;
    bus.req_ready_i  = 1'b0;
    bus.retire_i     = 1'b0;
    bus.retire_tid_i = '0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_credit();
    test_wrap_random();
    test_protocol_error();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
